mc_maindec: RTL and testbench
=============================

# mc_maindec

Multicycle main-control state machine for the MIPS core. It sequences a shared ALU, register file and unified memory across FETCH/DECODE/EXECUTE/MEM/WRITEBACK cycles. It drives the 2-bit `aluop` consumed by the ALU-control decoder, which stays a separate instance in the datapath. Memory accesses use a ready handshake, so instruction and data fetches may take any number of cycles.

## Interface
Parameters:
- none (encodings fixed in `mc_pkg`)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `op`  in  6  opcode from the instruction register, `instr[31:26]`
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completed the current access this cycle
- `mem_req`  out  1  memory access active
- `iord`  out  1  address select: 0 = PC, 1 = ALUOut
- `memwrite`  out  1  memory write strobe
- `irwrite`  out  1  instruction register load
- `pcen`  out  1  PC load, i.e. `pcwrite | (branch & zero)`
- `pcsrc`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `alusrca`  out  1  0 = PC, 1 = register A
- `alusrcb`  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- `aluop`  out  2  00 add, 01 sub, 10 use funct, 11 or
- `regdst`  out  1  1 = rd, 0 = rt
- `memtoreg`  out  1  1 = MDR, 0 = ALUOut
- `regwrite`  out  1  register file write
- `instr_done`  out  1  one-cycle pulse when an instruction retires
- `illegal_op`  out  1  one-cycle pulse in DECODE on an unknown opcode

## Operation
- Moore outputs are decoded from the state register. The exceptions are the handshake-gated strobes `irwrite`, `pcen` (in FETCH), `memwrite` and MEMRD completion.
- States and transitions:
  - FETCH: `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsrc`=00. `irwrite` and `pcwrite` equal `mem_ready`. Stays while `!mem_ready`; goes to DECODE on `mem_ready`.
  - DECODE: `alusrca`=0, `alusrcb`=11, `aluop`=00. Next state by `op`:
    - lw (100011) or sw (101011) → MEMADR
    - R-type (000000) → RTYPEEX
    - beq (000100) → BEQEX
    - addi (001000) → ADDIEX
    - ori (001101) → ORIEX
    - j (000010) → JEX
    - otherwise → FETCH, with `illegal_op`=1 and `instr_done`=1.
  - MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=00. Goes to MEMRD if lw, MEMWR if sw.
  - MEMRD: `mem_req`=1, `iord`=1. Waits for `mem_ready`, then MEMWB.
  - MEMWB: `regdst`=0, `memtoreg`=1, `regwrite`=1, `instr_done`=1. Goes to FETCH.
  - MEMWR: `mem_req`=1, `iord`=1, `memwrite`=1 held until `mem_ready`. On `mem_ready`: `instr_done`=1, then FETCH.
  - RTYPEEX: `alusrca`=1, `alusrcb`=00, `aluop`=10. Goes to RTYPEWB.
  - RTYPEWB: `regdst`=1, `memtoreg`=0, `regwrite`=1, `instr_done`=1. Goes to FETCH.
  - BEQEX: `alusrca`=1, `alusrcb`=00, `aluop`=01, `branch`=1, `pcsrc`=01, `instr_done`=1. Goes to FETCH.
  - ADDIEX: `alusrca`=1, `alusrcb`=10, `aluop`=00. Goes to IMMWB.
  - ORIEX: `alusrca`=1, `alusrcb`=10, `aluop`=11. Goes to IMMWB.
  - IMMWB: `regdst`=0, `memtoreg`=0, `regwrite`=1, `instr_done`=1. Goes to FETCH.
  - JEX: `pcsrc`=10, `pcwrite`=1, `instr_done`=1. Goes to FETCH.
- Outputs not listed for a state are 0.

## Timing
- Reset: state = FETCH, asynchronously. While `rst`=1, every write strobe is forced to 0: `irwrite`, `pcen`, `memwrite`, `regwrite`. `instr_done` and `illegal_op` are also forced to 0. `mem_req` is 0 during reset.
- Reset mid-instruction aborts it. No partial register-file write may occur after `rst` rises.
- Cycle counts with `mem_ready` tied to 1:
  - lw: 5
  - sw, R-type, addi, ori: 4
  - beq, j: 3
  - illegal opcode: 2
- Each memory wait cycle adds exactly one cycle. Non-memory states ignore `mem_ready`.
- `mem_ready` asserted outside FETCH/MEMRD/MEMWR has no effect.
- `memwrite` is held constant until the handshake completes.

## Structure
- `mc_pkg` holds:
  - the 4-bit state enum
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J)
  - aluop constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10, ALUOP_OR=11)
  - alusrcb and pcsrc select constants
- No sub-module: a single always_ff for the state register and a single always_comb for next-state and outputs. The ALU-control decoder remains external.

## Test plan
- Reset then lw (op=100011), `mem_ready`=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. `regwrite` and `memtoreg` are both 1 in cycle 5, with `instr_done` pulsing once.
- sw with `mem_ready` low for 3 cycles in MEMWR → `memwrite` held for 4 cycles, one `instr_done`, no `regwrite`, total 7 cycles.
- beq with `zero`=1, then with `zero`=0 → `pcen`=1 with `pcsrc`=01 and `aluop`=01 in BEQEX for the first; `pcen`=0 in BEQEX for the second.
- R-type then ori back-to-back → `aluop`=10 in RTYPEEX, then 11 in ORIEX; `regdst`=1 then 0 on writeback.
- op=111111 → `illegal_op` and `instr_done` pulse in DECODE, next state FETCH, no write strobes asserted.
- `rst` asserted during MEMWB → `regwrite` drops in the same cycle. After release, state is FETCH and the next `mem_ready` loads IR.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle main-control decoder: state enum,
// opcode values and the select codes driven onto the datapath muxes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ORIEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_JEX     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Decode of the opcode into the first execute-phase state; FETCH marks an
  // unknown opcode.
  function automatic state_t decode_next(input logic [5:0] opc);
    state_t nxt;
    case (opc)
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_RTYPE:     nxt = S_RTYPEEX;
      OP_BEQ:       nxt = S_BEQEX;
      OP_ADDI:      nxt = S_ADDIEX;
      OP_ORI:       nxt = S_ORIEX;
      OP_J:         nxt = S_JEX;
      default:      nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_maindec.sv
// Multicycle main-control state machine. Outputs are a Moore decode of the
// state register, except the memory-handshake strobes which follow mem_ready.
// While rst is high every strobe is forced low so an interrupted writeback
// can never commit.
module mc_maindec
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t state;
  state_t state_next;
  logic   pcwrite;
  logic   branch;

  // State register; reset returns to FETCH immediately, aborting any instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection and control-output decode, with reset gating of strobes.
  always_comb begin
    state_next = state;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    pcsrc      = PCSRC_ALU;
    alusrca    = 1'b0;
    alusrcb    = SRCB_B;
    aluop      = ALUOP_ADD;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb    = SRCB_IMMSH;
        state_next = decode_next(op);
        // An unknown opcode retires immediately without touching any state.
        if (decode_next(op) == S_FETCH) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
        end else begin
          illegal_op = 1'b0;
        end
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = mem_ready;
        state_next = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_FUNCT;
        state_next = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_SUB;
        branch     = 1'b1;
        pcsrc      = PCSRC_ALUOUT;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        state_next = S_IMMWB;
      end
      S_ORIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        aluop      = ALUOP_OR;
        state_next = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_JEX: begin
        pcsrc      = PCSRC_JUMP;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase

    // Reset overrides every strobe that could change architectural state.
    if (rst) begin
      mem_req    = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      pcen       = 1'b0;
    end else begin
      pcen = pcwrite | (branch & zero);
    end
  end

endmodule

// File: tb/tb_mc_maindec.sv
// Self-checking bench for mc_maindec. Each instruction is run against a
// cycle schedule derived from its class and the number of memory wait
// cycles; expected control words come from a per-phase table.
module tb_mc_maindec;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, iord, memwrite, irwrite, pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic       regdst, memtoreg, regwrite, instr_done, illegal_op;

  int total = 0;
  int bad   = 0;

  // instruction classes
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_ADDI = 4, C_ORI = 5, C_J = 6, C_ILL = 7;

  logic [16:0] obs_h [64];
  logic        rdy_h [64];
  logic        z_h   [64];
  int          ncyc;

  mc_maindec dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] out_vec();
    return {mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
            aluop, regdst, memtoreg, regwrite, instr_done, illegal_op};
  endfunction

  function automatic logic [5:0] op_of(int cls);
    case (cls)
      C_LW:    return 6'b100011;
      C_SW:    return 6'b101011;
      C_R:     return 6'b000000;
      C_BEQ:   return 6'b000100;
      C_ADDI:  return 6'b001000;
      C_ORI:   return 6'b001101;
      C_J:     return 6'b000010;
      default: return 6'b111111;
    endcase
  endfunction

  // Total cycles from first FETCH cycle to retirement.
  function automatic int len_of(int cls, int fw, int mw);
    case (cls)
      C_LW:             return fw + mw + 5;
      C_SW:             return fw + mw + 4;
      C_R, C_ADDI, C_ORI: return fw + 4;
      C_BEQ, C_J:       return fw + 3;
      default:          return fw + 2;
    endcase
  endfunction

  // Is cycle c a memory data-access cycle for this instruction?
  function automatic bit in_mem(int cls, int c, int fw, int mw);
    return (cls == C_LW || cls == C_SW) && c >= fw + 4 && c <= fw + 4 + mw;
  endfunction

  // Expected control word for cycle c (1-based) of an instruction.
  function automatic logic [16:0] exp_vec(int cls, int c, int fw, int mw, logic rdy, logic z);
    logic mrq = 0, ird = 0, mwr = 0, irw = 0, pce = 0, asa = 0, rdst = 0, m2r = 0, rw = 0, dn = 0, ill = 0;
    logic [1:0] psrc = 2'b00, asb = 2'b00, aop = 2'b00;
    if (c <= fw + 1) begin
      mrq = 1; asb = 2'b01; irw = rdy; pce = rdy;
    end else if (c == fw + 2) begin
      asb = 2'b11;
      if (cls == C_ILL) begin ill = 1; dn = 1; end
    end else if (c == fw + 3) begin
      case (cls)
        C_LW, C_SW: begin asa = 1; asb = 2'b10; end
        C_R:        begin asa = 1; aop = 2'b10; end
        C_BEQ:      begin asa = 1; aop = 2'b01; psrc = 2'b01; pce = z; dn = 1; end
        C_ADDI:     begin asa = 1; asb = 2'b10; end
        C_ORI:      begin asa = 1; asb = 2'b10; aop = 2'b11; end
        C_J:        begin psrc = 2'b10; pce = 1; dn = 1; end
        default:    begin end
      endcase
    end else if (in_mem(cls, c, fw, mw)) begin
      mrq = 1; ird = 1;
      if (cls == C_SW) begin mwr = 1; dn = rdy; end
    end else begin
      // writeback cycle
      rw = 1; dn = 1;
      rdst = (cls == C_R);
      m2r  = (cls == C_LW);
    end
    return {mrq, ird, mwr, irw, pce, psrc, asa, asb, aop, rdst, m2r, rw, dn, ill};
  endfunction

  // Drives one instruction for cycles 1..stop-1 (stop<=0: whole instruction),
  // recording outputs at each negedge. Entered and left just after a posedge.
  task automatic run_instr(input int cls, input logic [5:0] opc, input int fw, input int mw,
                           input int zmode, input int stop);
    int n = len_of(cls, fw, mw);
    if (stop > 0) n = stop - 1;
    ncyc = n;
    for (int c = 1; c <= n; c++) begin
      if (c <= fw) rdy_h[c] = 1'b0;
      else if (c == fw + 1) rdy_h[c] = 1'b1;
      else if (in_mem(cls, c, fw, mw)) rdy_h[c] = (c == fw + 4 + mw);
      else rdy_h[c] = 1'($urandom_range(0, 1));
      z_h[c] = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      op = (c <= fw + 1) ? 6'($urandom_range(0, 63)) : opc;
      mem_ready = rdy_h[c];
      zero = z_h[c];
      @(negedge clk);
      obs_h[c] = out_vec();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; op = 6'b100011; zero = 1'b1; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (out_vec() !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 5'b00000}) begin
      bad++; $display("FAIL reset_outputs got=%b want=%b", out_vec(),
                      {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 5'b00000});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_lw();
    int ndone = 0;
    run_instr(C_LW, op_of(C_LW), 0, 0, -1, 0);
    total++;
    if (ncyc !== 5) begin bad++; $display("FAIL lw_len got=%0d want=5", ncyc); end
    for (int c = 1; c <= ncyc; c++) begin
      total++;
      if (obs_h[c] !== exp_vec(C_LW, c, 0, 0, rdy_h[c], z_h[c])) begin
        bad++; $display("FAIL lw cyc=%0d got=%b want=%b", c, obs_h[c], exp_vec(C_LW, c, 0, 0, rdy_h[c], z_h[c]));
      end
      ndone += int'(obs_h[c][1]);
    end
    total++;
    if (obs_h[5][4:2] !== 3'b011 || ndone != 1) begin
      bad++; $display("FAIL lw_wb got=%b done_count=%0d want=011 and 1", obs_h[5][4:2], ndone);
    end
  endtask

  task automatic test_sw_wait();
    int nmw = 0, nrw = 0, ndone = 0;
    run_instr(C_SW, op_of(C_SW), 0, 3, -1, 0);
    for (int c = 1; c <= ncyc; c++) begin
      total++;
      if (obs_h[c] !== exp_vec(C_SW, c, 0, 3, rdy_h[c], z_h[c])) begin
        bad++; $display("FAIL sw cyc=%0d got=%b want=%b", c, obs_h[c], exp_vec(C_SW, c, 0, 3, rdy_h[c], z_h[c]));
      end
      nmw += int'(obs_h[c][14]); nrw += int'(obs_h[c][2]); ndone += int'(obs_h[c][1]);
    end
    total++;
    if (nmw != 4 || nrw != 0 || ndone != 1 || ncyc != 7) begin
      bad++; $display("FAIL sw_summary got memwrite=%0d regwrite=%0d done=%0d len=%0d want 4 0 1 7", nmw, nrw, ndone, ncyc);
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      run_instr(C_BEQ, op_of(C_BEQ), 0, 0, z, 0);
      for (int c = 1; c <= ncyc; c++) begin
        total++;
        if (obs_h[c] !== exp_vec(C_BEQ, c, 0, 0, rdy_h[c], z_h[c])) begin
          bad++; $display("FAIL beq_z%0d cyc=%0d got=%b want=%b", z, c, obs_h[c], exp_vec(C_BEQ, c, 0, 0, rdy_h[c], z_h[c]));
        end
      end
      total++;
      if (obs_h[3][12] !== 1'(z)) begin
        bad++; $display("FAIL beq_pcen z=%0d got=%b want=%0d", z, obs_h[3][12], z);
      end
    end
  endtask

  task automatic test_back_to_back();
    int seq [2] = '{C_R, C_ORI};
    for (int k = 0; k < 2; k++) begin
      run_instr(seq[k], op_of(seq[k]), 1, 0, -1, 0);
      for (int c = 1; c <= ncyc; c++) begin
        total++;
        if (obs_h[c] !== exp_vec(seq[k], c, 1, 0, rdy_h[c], z_h[c])) begin
          bad++; $display("FAIL b2b_%0d cyc=%0d got=%b want=%b", k, c, obs_h[c], exp_vec(seq[k], c, 1, 0, rdy_h[c], z_h[c]));
        end
      end
    end
  endtask

  task automatic test_illegal();
    run_instr(C_ILL, 6'b111111, 0, 0, -1, 0);
    total++;
    if (ncyc !== 2) begin bad++; $display("FAIL ill_len got=%0d want=2", ncyc); end
    for (int c = 1; c <= ncyc; c++) begin
      total++;
      if (obs_h[c] !== exp_vec(C_ILL, c, 0, 0, rdy_h[c], z_h[c])) begin
        bad++; $display("FAIL illegal cyc=%0d got=%b want=%b", c, obs_h[c], exp_vec(C_ILL, c, 0, 0, rdy_h[c], z_h[c]));
      end
    end
  endtask

  task automatic test_reset_mid();
    run_instr(C_LW, op_of(C_LW), 0, 0, -1, 5);
    for (int c = 1; c <= ncyc; c++) begin
      total++;
      if (obs_h[c] !== exp_vec(C_LW, c, 0, 0, rdy_h[c], z_h[c])) begin
        bad++; $display("FAIL rstmid_pre cyc=%0d got=%b want=%b", c, obs_h[c], exp_vec(C_LW, c, 0, 0, rdy_h[c], z_h[c]));
      end
    end
    mem_ready = 1'b1;
    #1;
    total++;
    if (regwrite !== 1'b1) begin bad++; $display("FAIL rstmid_wb got=%b want=1", regwrite); end
    rst = 1'b1;
    #1;
    total++;
    if ({regwrite, instr_done, memwrite, irwrite, pcen, mem_req} !== 6'b000000) begin
      bad++; $display("FAIL rstmid_strobes got=%b want=000000", {regwrite, instr_done, memwrite, irwrite, pcen, mem_req});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr(C_ADDI, op_of(C_ADDI), 1, 0, -1, 0);
    for (int c = 1; c <= ncyc; c++) begin
      total++;
      if (obs_h[c] !== exp_vec(C_ADDI, c, 1, 0, rdy_h[c], z_h[c])) begin
        bad++; $display("FAIL rstmid_post cyc=%0d got=%b want=%b", c, obs_h[c], exp_vec(C_ADDI, c, 1, 0, rdy_h[c], z_h[c]));
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 150; k++) begin
      int cls = $urandom_range(0, 7);
      int fw  = $urandom_range(0, 3);
      int mw  = $urandom_range(0, 3);
      logic [5:0] opc = op_of(cls);
      if (cls == C_ILL) begin
        do opc = 6'($urandom_range(0, 63));
        while (opc inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b001101, 6'b000010});
      end
      run_instr(cls, opc, fw, mw, -1, 0);
      for (int c = 1; c <= ncyc; c++) begin
        total++;
        if (obs_h[c] !== exp_vec(cls, c, fw, mw, rdy_h[c], z_h[c])) begin
          bad++; $display("FAIL rand k=%0d cls=%0d op=%b cyc=%0d got=%b want=%b", k, cls, opc, c,
                          obs_h[c], exp_vec(cls, c, fw, mw, rdy_h[c], z_h[c]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
